// File: rtl/apb_cmd_master_if.sv
// Command/response port and APB3 bus of apb_cmd_master, bundled for connection.
// The master modport is the initiator's view; slave is the sequencer/peripheral side.
interface apb_cmd_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic                  CMD_WRITE;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [DATA_WIDTH-1:0] CMD_WDATA;

  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  logic                  RSP_TIMEOUT;
  logic                  BUSY;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY, PSLVERR,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT, BUSY,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY, PSLVERR,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT, BUSY,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 initiator: one valid/ready command becomes one SETUP/ACCESS
// transfer whose result is held on the response port until accepted.
module apb_cmd_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 256
) (
  input logic                PCLK,
  input logic                PRESET,
  apb_cmd_master_if.master   bus
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_t;

  state_t                state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.CMD_VALID) begin
            paddr_q  <= bus.CMD_ADDR;
            pwrite_q <= bus.CMD_WRITE;
            if (bus.CMD_WRITE) begin
              pwdata_q <= bus.CMD_WDATA;
            end
            psel_q  <= 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StAccess;
        end
        StAccess: begin
          // Completion wins over an expiring timeout in the same cycle.
          if (bus.PREADY) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
            rsp_err_q     <= bus.PSLVERR;
            rsp_timeout_q <= 1'b0;
            state_q       <= StResp;
          end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= StResp;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (bus.RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus.CMD_READY   = (state_q == StIdle);
  assign bus.BUSY        = (state_q != StIdle);
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.RSP_VALID   = rsp_valid_q;
  assign bus.RSP_RDATA   = rsp_rdata_q;
  assign bus.RSP_ERR     = rsp_err_q;
  assign bus.RSP_TIMEOUT = rsp_timeout_q;

endmodule
